nx_instr_fetch: RTL

NX_INSTR_FETCH -- requirements
Module: nx_instr_fetch

---
 rtl/nx_fetch_pkg.sv | 19 +
 rtl/nx_fetch_fifo.sv | 65 ++++++
 rtl/nx_instr_fetch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nx_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and the
// prefetch FIFO entry carried from the store read port to the core.
package nx_fetch_pkg;

  // Widest instruction word the FIFO entry can carry; narrower words are zero-padded.
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] data;
    logic                    last;
  } fetch_entry_t;

endpackage

// File: rtl/nx_fetch_fifo.sv
// Prefetch FIFO for nx_instr_fetch: power-of-two depth, pointers wrap naturally,
// occupancy exported so the fetcher can throttle requests before it fills.
module nx_fetch_fifo
  import nx_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != FULL_C) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/nx_instr_fetch.sv
// Instruction fetch unit: streams instructions 0..N-1 from the store through a
// prefetch FIFO to the core. Define NX_INSTR_FETCH_PERF_EN to add stall_count_o.
module nx_instr_fetch
  import nx_fetch_pkg::*;
#(
  parameter int  INSTR_WIDTH = 15,
  parameter int  MAX_INSTRS  = 512,
  parameter int  FIFO_DEPTH  = 4,
  localparam int AW          = $clog2(MAX_INSTRS),
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AW-1:0]          instr_count_i,
  input  logic                   start_i,
  output logic                   idle_o,
  output logic [AW-1:0]          fetch_addr_o,
  output logic                   fetch_rd_o,
  input  logic [INSTR_WIDTH-1:0] fetch_data_i,
  input  logic                   fetch_stall_i,
  output logic [INSTR_WIDTH-1:0] instr_data_o,
  output logic                   instr_last_o,
  output logic                   instr_valid_o,
`ifdef NX_INSTR_FETCH_PERF_EN
  output logic [15:0]            stall_count_o,
`endif
  input  logic                   instr_ready_i
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] cur_pc, cur_count;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          start_ok, issue, accept, at_last, pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head, fifo_wdata;

  // The first request goes out in the start cycle itself so the first word
  // reaches the core two cycles after start_i.
  always_comb begin
    start_ok  = (state_q == ST_IDLE) && start_i && (instr_count_i != '0);
    cur_pc    = (state_q == ST_FETCH) ? pc_q : '0;
    cur_count = (state_q == ST_IDLE) ? instr_count_i : count_q;
    issue     = start_ok ||
                ((state_q == ST_FETCH) && ((fifo_count + CW'(inflight_q)) < DEPTH_C));
    accept    = issue && !fetch_stall_i;
    at_last   = (cur_pc == cur_count - AW'(1));
    pop       = !fifo_empty && instr_ready_i;
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    count_d         = count_q;
    inflight_d      = accept;
    inflight_last_d = accept && at_last;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          count_d = instr_count_i;
          pc_d    = accept ? AW'(1) : '0;
          state_d = (accept && at_last) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (accept) begin
          pc_d = pc_q + AW'(1);
          if (at_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_head.last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= ST_IDLE;
      pc_q            <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.data = FETCH_DATA_W'(fetch_data_i);
    fifo_wdata.last = inflight_last_q;
  end

  nx_fetch_fifo #(
    .entry_t (fetch_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head contents are masked while empty so stale storage never reaches the core.
  assign idle_o        = (state_q == ST_IDLE);
  assign fetch_addr_o  = cur_pc;
  assign fetch_rd_o    = issue && rst_i;
  assign instr_valid_o = !fifo_empty;
  assign instr_data_o  = instr_valid_o ? fifo_head.data[INSTR_WIDTH-1:0] : '0;
  assign instr_last_o  = instr_valid_o && fifo_head.last;

  if (INSTR_WIDTH < FETCH_DATA_W) begin : g_pad_unused
    logic unused_pad;
    assign unused_pad = ^fifo_head.data[FETCH_DATA_W-1:INSTR_WIDTH];
  end

`ifdef NX_INSTR_FETCH_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = start_ok ? 16'd0 : stall_count_q;
    if (fetch_rd_o && fetch_stall_i && (stall_count_d != 16'hFFFF)) begin
      stall_count_d = stall_count_d + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count_o = stall_count_q;
`endif

endmodule
